// File: rtl/carfield_fpga_rst_seq.sv
// FPGA reset sequencer: debounces the board button, waits for MIG calibration, then releases the SoC.
// Optional watchdog enabled by defining CARFIELD_RST_SEQ_WDT_EN (adds WdtCycles and wdt_kick_i).
module carfield_fpga_rst_seq #(
  parameter int unsigned DebounceCycles = 1024,
  parameter int unsigned HoldCycles     = 256,
  parameter int unsigned CalibTimeout   = 2**20,
  parameter int unsigned CntWidth       = 21
`ifdef CARFIELD_RST_SEQ_WDT_EN
  ,
  parameter int unsigned WdtCycles      = 2**24
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_rst_i,
  input  logic       calib_done_i,
`ifdef CARFIELD_RST_SEQ_WDT_EN
  input  logic       wdt_kick_i,
`endif
  output logic       soc_rst_no,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o,
  output logic       error_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_CALIB = 3'd1,
    ST_HOLD       = 3'd2,
    ST_RUN        = 3'd3,
    ST_BTN        = 3'd4,
    ST_ERROR      = 3'd5
  } state_e;

  localparam int unsigned DebW = $clog2(DebounceCycles + 1);
  localparam logic [DebW-1:0]     DebLast   = DebW'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(HoldCycles - 1);
  localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeout - 1);

  logic [1:0]          btn_sync_q, btn_sync_d;
  logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;
  logic                btn_q, btn_d;
  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic [7:0]          count_q, count_d;
  logic                soc_rst_n_q, soc_rst_n_d;
  logic                error_q, error_d;
  logic                wdt_expired;

  // A sample equal to the accepted level restarts the count, so only an unbroken run flips btn_q.
  always_comb begin
    btn_sync_d = {btn_sync_q[0], btn_rst_i};
    deb_cnt_d  = deb_cnt_q;
    btn_d      = btn_q;
    if (btn_sync_q[1] == btn_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebLast) begin
      btn_d     = btn_sync_q[1];
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DebW'(1);
    end
  end

`ifdef CARFIELD_RST_SEQ_WDT_EN
  localparam int unsigned WdtW = $clog2(WdtCycles + 1);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WdtCycles - 1);

  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;

  assign wdt_expired = (state_q == ST_RUN) && !wdt_kick_i && (wdt_cnt_q == WdtLast);

  always_comb begin
    wdt_cnt_d = wdt_cnt_q + WdtW'(1);
    if (state_d != ST_RUN || wdt_kick_i) wdt_cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wdt_cnt_q <= '0;
    else       wdt_cnt_q <= wdt_cnt_d;
  end
`else
  assign wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    count_d = count_q;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_CALIB;
        cnt_d   = '0;
      end
      ST_WAIT_CALIB: begin
        if (calib_done_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CalibLast) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_HOLD: begin
        if (!calib_done_i) begin
          state_d = ST_WAIT_CALIB;
          cause_d = 2'd2;
          cnt_d   = '0;
        end else if (btn_q) begin
          state_d = ST_BTN;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!calib_done_i || btn_q || wdt_expired) begin
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
          if (!calib_done_i) begin
            state_d = ST_WAIT_CALIB;
            cause_d = 2'd2;
          end else if (btn_q) begin
            state_d = ST_BTN;
            cause_d = 2'd1;
          end else begin
            state_d = ST_HOLD;
            cause_d = 2'd3;
          end
        end
      end
      ST_BTN: begin
        cnt_d = '0;
        if (!calib_done_i) begin
          state_d = ST_WAIT_CALIB;
          cause_d = 2'd2;
        end else if (!btn_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
    soc_rst_n_d = (state_d == ST_RUN);
    error_d     = error_q || (state_d == ST_ERROR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_sync_q  <= '0;
      deb_cnt_q   <= '0;
      btn_q       <= 1'b0;
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      cause_q     <= 2'd0;
      count_q     <= 8'd0;
      soc_rst_n_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      btn_sync_q  <= btn_sync_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_q       <= btn_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      soc_rst_n_q <= soc_rst_n_d;
      error_q     <= error_d;
    end
  end

  assign soc_rst_no  = soc_rst_n_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = count_q;
  assign error_o     = error_q;
  assign state_o     = state_q;

endmodule
